debounce_multi: RTL and testbench

- Parametrised, multi-channel successor to the single-pin debouncer; filters N_CH mechanical key/switch inputs.
- Per channel it provides:
  - input synchronisation;
  - a clean debounced level;
  - one-cycle press and release pulses;
  - a one-shot long-press pulse.
- It sits between board pins and the key/UI logic. It replaces separate edge-detect plus delay pairs with one counter-based FSM per channel.

---
 rtl/debounce_pkg.sv | 29 ++
 rtl/debounce_channel.sv | 134 +++++++++++++
 rtl/debounce_multi.sv | 51 +++++
 tb/tb_debounce_multi.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel key debouncer.
package debounce_pkg;

   // Per-channel debounce FSM states.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DB_PRESS = 2'd1,
      PRESSED  = 2'd2,
      DB_REL   = 2'd3
   } db_state_e;

   // Idle (released) pin level for the chosen polarity.
   function automatic logic idle_level(input bit active_low);
      return active_low ? 1'b1 : 1'b0;
   endfunction

   // Width of the debounce counter; it only ever needs to hold DB_CYCLES-1.
   function automatic int db_cnt_width(input int db_cycles);
      if (db_cycles < 2) return 1;
      return $clog2(db_cycles);
   endfunction

   // Width of the long-press counter; it saturates at LONG_CYCLES.
   function automatic int long_cnt_width(input int long_cycles);
      if (long_cycles < 1) return 1;
      return $clog2(long_cycles + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced key: synchroniser, 4-state debounce FSM, debounce and
// long-press counters, and registered level/pulse outputs.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 500000,
   parameter int LONG_CYCLES = 50000000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic pin_in,
   output logic pin_out,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam int               DB_W     = db_cnt_width(DB_CYCLES);
   localparam int               LONG_W   = long_cnt_width(LONG_CYCLES);
   localparam logic             IDLE_LVL = idle_level(ACTIVE_LOW);
   localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
   localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);
   localparam bit               LONG_EN  = (LONG_CYCLES != 0);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   sync;
   db_state_e              state_q, state_d;
   logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
   logic [LONG_W-1:0]      long_cnt_q, long_cnt_d;
   logic                   pin_out_q, pin_out_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;
   logic                   long_q, long_d;

   assign sync          = sync_q[SYNC_STAGES-1];
   assign pin_out       = pin_out_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign long_pulse    = long_q;

   // Next-state logic: shift the synchroniser and step the debounce FSM.
   // The long-press counter keeps running through DB_REL so that a bouncing
   // release still counts as held time; it saturates for a single pulse.
   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], pin_in};
      state_d    = state_q;
      db_cnt_d   = db_cnt_q;
      long_cnt_d = long_cnt_q;
      pin_out_d  = pin_out_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      long_d     = 1'b0;

      if ((state_q == PRESSED || state_q == DB_REL) && LONG_EN && long_cnt_q != LONG_MAX) begin
         long_cnt_d = long_cnt_q + LONG_W'(1);
         long_d     = (long_cnt_d == LONG_MAX);
      end

      case (state_q)
         IDLE: begin
            pin_out_d  = IDLE_LVL;
            long_cnt_d = '0;
            if (sync != IDLE_LVL) begin
               state_d  = DB_PRESS;
               db_cnt_d = DB_W'(1);
            end
         end
         DB_PRESS: begin
            if (sync == IDLE_LVL) begin
               state_d  = IDLE;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d    = PRESSED;
               db_cnt_d   = '0;
               long_cnt_d = '0;
               pin_out_d  = ~IDLE_LVL;
               press_d    = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end
         PRESSED: begin
            if (sync == IDLE_LVL) begin
               state_d  = DB_REL;
               db_cnt_d = DB_W'(1);
            end
         end
         DB_REL: begin
            if (sync != IDLE_LVL) begin
               state_d  = PRESSED;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d    = IDLE;
               db_cnt_d   = '0;
               long_cnt_d = '0;
               long_d     = 1'b0;
               pin_out_d  = IDLE_LVL;
               release_d  = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any count or pending pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= {SYNC_STAGES{IDLE_LVL}};
         state_q    <= IDLE;
         db_cnt_q   <= '0;
         long_cnt_q <= '0;
         pin_out_q  <= IDLE_LVL;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         long_q     <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         state_q    <= state_d;
         db_cnt_q   <= db_cnt_d;
         long_cnt_q <= long_cnt_d;
         pin_out_q  <= pin_out_d;
         press_q    <= press_d;
         release_q  <= release_d;
         long_q     <= long_d;
      end
   end

endmodule

// File: rtl/debounce_multi.sv
// N_CH independent key debouncers with press, release and long-press pulses.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 500000,
   parameter int LONG_CYCLES = 50000000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [N_CH-1:0] Pin_In,
   output logic [N_CH-1:0] Pin_Out,
   output logic [N_CH-1:0] Press_Pulse,
   output logic [N_CH-1:0] Release_Pulse,
   output logic [N_CH-1:0] Long_Pulse
);

   // Refuse to elaborate with parameter values the channel logic cannot honour.
   if (N_CH < 1) begin : g_bad_n_ch
      $error("debounce_multi: N_CH must be at least 1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("debounce_multi: SYNC_STAGES must be at least 2");
   end
   if (DB_CYCLES < 2) begin : g_bad_db
      $error("debounce_multi: DB_CYCLES must be at least 2");
   end
   if (LONG_CYCLES < 0 || (LONG_CYCLES != 0 && LONG_CYCLES <= DB_CYCLES)) begin : g_bad_long
      $error("debounce_multi: LONG_CYCLES must be 0 or greater than DB_CYCLES");
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_CYCLES   (DB_CYCLES),
         .LONG_CYCLES (LONG_CYCLES),
         .ACTIVE_LOW  (ACTIVE_LOW)
      ) u_ch (
         .clk           (CLK),
         .rst           (RST),
         .pin_in        (Pin_In[i]),
         .pin_out       (Pin_Out[i]),
         .press_pulse   (Press_Pulse[i]),
         .release_pulse (Release_Pulse[i]),
         .long_pulse    (Long_Pulse[i])
      );
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: stimulus queues the pulses it expects,
// a monitor pops them as the DUT pulses and checks cycle, vectors and level.
module tb_debounce_multi;

   logic       clk;
   logic       rst;
   logic [3:0] pin_in;
   logic [3:0] pin_out;
   logic [3:0] press_pulse;
   logic [3:0] release_pulse;
   logic [3:0] long_pulse;

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         cyc;
      logic [3:0] press;
      logic [3:0] rel;
      logic [3:0] lng;
      logic [3:0] pins;
   } exp_t;

   exp_t exp_q[$];

   debounce_multi #(
      .N_CH        (4),
      .SYNC_STAGES (2),
      .DB_CYCLES   (8),
      .LONG_CYCLES (32),
      .ACTIVE_LOW  (1'b1)
   ) dut (
      .CLK           (clk),
      .RST           (rst),
      .Pin_In        (pin_in),
      .Pin_Out       (pin_out),
      .Press_Pulse   (press_pulse),
      .Release_Pulse (release_pulse),
      .Long_Pulse    (long_pulse)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count rising edges so stimulus and monitor share one timeline.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void expectPulse(input int at, input logic [3:0] press,
                                       input logic [3:0] rel, input logic [3:0] lng,
                                       input logic [3:0] pins);
      exp_t e;
      e.cyc   = at;
      e.press = press;
      e.rel   = rel;
      e.lng   = lng;
      e.pins  = pins;
      exp_q.push_back(e);
   endfunction

   task automatic waitUntil(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [3:0] pins);
      pin_in = pins;
   endtask

   // Quiet-cycle check: level as given and no pulse on any channel.
   task automatic checkOutput(input string name, input logic [3:0] exp_pins);
      checks++;
      if (pin_out !== exp_pins || press_pulse !== 4'b0 ||
          release_pulse !== 4'b0 || long_pulse !== 4'b0) begin
         failures++;
         $display("[TB] FAIL %s @%0d: got pins=%b press=%b rel=%b long=%b, expected pins=%b and no pulses",
                  name, cyc, pin_out, press_pulse, release_pulse, long_pulse, exp_pins);
      end
   endtask

   // Monitor: retire overdue expectations, then match any pulse cycle.
   always @(negedge clk) begin : monitor
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         checks++;
         failures++;
         $display("[TB] FAIL missed_pulse: expected pulse at %0d not seen (press=%b rel=%b long=%b)",
                  exp_q[0].cyc, exp_q[0].press, exp_q[0].rel, exp_q[0].lng);
         void'(exp_q.pop_front());
      end
      if ((press_pulse | release_pulse | long_pulse) != 4'b0) begin
         checks++;
         if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
            failures++;
            $display("[TB] FAIL unexpected_pulse @%0d: got press=%b rel=%b long=%b, expected none",
                     cyc, press_pulse, release_pulse, long_pulse);
         end else begin
            e = exp_q.pop_front();
            if (press_pulse !== e.press || release_pulse !== e.rel ||
                long_pulse !== e.lng || pin_out !== e.pins) begin
               failures++;
               $display("[TB] FAIL pulse@%0d: got press=%b rel=%b long=%b pins=%b, expected press=%b rel=%b long=%b pins=%b",
                        cyc, press_pulse, release_pulse, long_pulse, pin_out,
                        e.press, e.rel, e.lng, e.pins);
            end
         end
      end
   end

   // Directed test sequence with hand-computed pulse cycles (latency 10 edges).
   initial begin
      rst    = 1'b1;
      pin_in = 4'b0000;

      // Reset held for edges 1..3 with all pins pressed; press lands at 3+10.
      expectPulse(13, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
      waitUntil(1);
      checkOutput("reset_cycle1", 4'b1111);
      waitUntil(2);
      checkOutput("reset_cycle2", 4'b1111);
      waitUntil(3);
      rst = 1'b0;
      waitUntil(4);
      checkOutput("post_reset", 4'b1111);
      waitUntil(12);
      checkOutput("no_early_press", 4'b1111);
      waitUntil(14);
      applyStimulus(4'b1111);
      expectPulse(24, 4'b0000, 4'b1111, 4'b0000, 4'b1111);

      // Clean press and release on channel 0.
      waitUntil(30);
      applyStimulus(4'b1110);
      expectPulse(40, 4'b0001, 4'b0000, 4'b0000, 4'b1110);
      waitUntil(39);
      checkOutput("ch0_before_accept", 4'b1111);
      waitUntil(45);
      checkOutput("ch0_held", 4'b1110);
      applyStimulus(4'b1111);
      expectPulse(55, 4'b0000, 4'b0001, 4'b0000, 4'b1111);

      // Channel 1: 7-cycle low rejected, 8-cycle low accepted.
      waitUntil(60);
      applyStimulus(4'b1101);
      waitUntil(67);
      applyStimulus(4'b1111);
      waitUntil(75);
      checkOutput("glitch7_rejected", 4'b1111);
      waitUntil(80);
      applyStimulus(4'b1101);
      expectPulse(90, 4'b0010, 4'b0000, 4'b0000, 4'b1101);
      expectPulse(98, 4'b0000, 4'b0010, 4'b0000, 4'b1111);
      waitUntil(88);
      applyStimulus(4'b1111);

      // Channel 2 bounces every 3 cycles, final low at 147 -> press at 157.
      expectPulse(157, 4'b0100, 4'b0000, 4'b0000, 4'b1011);
      for (int k = 0; k <= 14; k++) begin
         waitUntil(105 + 3 * k);
         applyStimulus((k % 2 == 0) ? 4'b1011 : 4'b1111);
      end
      waitUntil(150);
      checkOutput("bounce_quiet", 4'b1111);
      waitUntil(165);
      applyStimulus(4'b1111);
      expectPulse(175, 4'b0000, 4'b0100, 4'b0000, 4'b1111);

      // Channel 3 long press: press 190, long 190+32, release 240+10.
      waitUntil(180);
      applyStimulus(4'b0111);
      expectPulse(190, 4'b1000, 4'b0000, 4'b0000, 4'b0111);
      expectPulse(222, 4'b0000, 4'b0000, 4'b1000, 4'b0111);
      expectPulse(250, 4'b0000, 4'b1000, 4'b0000, 4'b1111);
      waitUntil(230);
      checkOutput("long_held", 4'b0111);
      waitUntil(240);
      applyStimulus(4'b1111);

      // Short second press on channel 3: no long pulse.
      waitUntil(255);
      applyStimulus(4'b0111);
      expectPulse(265, 4'b1000, 4'b0000, 4'b0000, 4'b0111);
      expectPulse(285, 4'b0000, 4'b1000, 4'b0000, 4'b1111);
      waitUntil(275);
      applyStimulus(4'b1111);
      waitUntil(300);
      checkOutput("short_press_done", 4'b1111);

      // All channels pressed and released together.
      waitUntil(310);
      applyStimulus(4'b0000);
      expectPulse(320, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
      waitUntil(325);
      applyStimulus(4'b1111);
      expectPulse(335, 4'b0000, 4'b1111, 4'b0000, 4'b1111);

      // Reset lands on the 5th debounce cycle (edge 347) of a fresh press.
      waitUntil(340);
      applyStimulus(4'b0000);
      waitUntil(346);
      rst = 1'b1;
      applyStimulus(4'b1111);
      waitUntil(347);
      checkOutput("mid_op_reset", 4'b1111);
      waitUntil(348);
      rst = 1'b0;
      waitUntil(370);
      checkOutput("after_mid_reset", 4'b1111);

      waitUntil(400);
      while (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL missed_pulse_end: expected pulse at %0d never seen", exp_q[0].cyc);
         void'(exp_q.pop_front());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
